// File: rtl/tape_pkg.sv
// Shared types and constants for the tape buffer RAM arbiter.
// Used by tape_wr_buf and tape_ram_arbiter.
package tape_pkg;

    localparam int         TAPE_AW        = 16;
    localparam logic [7:0] TAPE_SYNC_BYTE = 8'h16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD      = 2'd2,
        RD_WAIT = 2'd3
    } tape_state_e;

endpackage

// File: rtl/tape_wr_buf.sv
// One-entry write buffer between the ioctl strobe and the tape RAM.
// A strobe that arrives while the entry is occupied is dropped.
module tape_wr_buf
    import tape_pkg::*;
#(
    parameter int AW = TAPE_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          clear,
    output logic          full,
    output logic [AW-1:0] buf_addr,
    output logic [7:0]    buf_data
);

    logic          full_q, full_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    data_q, data_d;

    always_comb begin
        full_d = full_q;
        addr_d = addr_q;
        data_d = data_q;
        if (clear) begin
            full_d = 1'b0;
        end else if (wr && !full_q) begin
            full_d = 1'b1;
            addr_d = wr_addr;
            data_d = wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign full     = full_q;
    assign buf_addr = addr_q;
    assign buf_data = data_q;

endmodule

// File: rtl/tape_ram_arbiter.sv
// Shares the single-port tape RAM between ioctl TAP downloads and cassette reads, tracks tape length
// and sequences the player. Define TAPE_AUTOREWIND_EN to also rewind on load end and on tape run-out.
module tape_ram_arbiter
    import tape_pkg::*;
#(
    parameter int AW     = TAPE_AW,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          ioctl_wait,
    input  logic [AW-1:0] cas_addr,
    output logic [7:0]    cas_data,
    input  logic          motor,
    input  logic          rewind_req,
    output logic          cas_en,
    output logic          cas_rewind,
    output logic [AW-1:0] tape_end,
    output logic          tape_loaded,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    input  logic [7:0]    ram_dout
);

    tape_state_e   state_q, state_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [1:0]    wait_cnt_q, wait_cnt_d;
    logic [7:0]    cas_data_q, cas_data_d;
    logic [AW-1:0] max_addr_q, max_addr_d;
    logic          any_wr_q, any_wr_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] tape_end_q, tape_end_d;
    logic          tape_loaded_q, tape_loaded_d;
    logic          cas_en_q, cas_en_d;
    logic          rewind_q, rewind_d;
    logic          dl_q, dl_d;
    logic          rew_req_q, rew_req_d;

    logic          buf_full;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_data;
    logic          dl_rise, dl_fall, rew_rise, finalize, toggle;

    tape_wr_buf #(.AW(AW)) u_wr_buf (
        .clk      (clk),
        .reset    (reset),
        .wr       (ioctl_wr),
        .wr_addr  (ioctl_addr),
        .wr_data  (ioctl_dout),
        .clear    (state_q == WR),
        .full     (buf_full),
        .buf_addr (buf_addr),
        .buf_data (buf_data)
    );

    // Writes win arbitration; a read issues cas_addr live and captures after RD_LAT wait cycles.
    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        wait_cnt_d = wait_cnt_q;
        cas_data_d = cas_data_q;
        ram_addr   = '0;
        ram_din    = '0;
        ram_we     = 1'b0;
        case (state_q)
            IDLE: state_d = buf_full ? WR : RD;
            WR: begin
                ram_addr = buf_addr;
                ram_din  = buf_data;
                ram_we   = 1'b1;
                state_d  = IDLE;
            end
            RD: begin
                ram_addr   = cas_addr;
                rd_addr_d  = cas_addr;
                wait_cnt_d = 2'(RD_LAT - 1);
                state_d    = RD_WAIT;
            end
            RD_WAIT: begin
                ram_addr = rd_addr_q;
                if (wait_cnt_q == 2'd0) begin
                    cas_data_d = ram_dout;
                    state_d    = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dl_rise  = ioctl_download & ~dl_q;
    assign dl_fall  = ~ioctl_download & dl_q;
    assign rew_rise = rewind_req & ~rew_req_q;
    // The length is only published once the last buffered byte has reached the RAM.
    assign finalize = (dl_fall | pend_q) & ~buf_full & (state_q != WR);

`ifdef TAPE_AUTOREWIND_EN
    logic loaded_prev_q, loaded_prev_d;
    logic motor_q, motor_d;
    logic sup_q, sup_d;
    logic load_evt, runout;

    assign load_evt = tape_loaded_q & ~loaded_prev_q;
    assign runout   = ~motor & motor_q & tape_loaded_q & (cas_addr == tape_end_q);

    // A user rewind during load completion replaces the automatic one, so only one toggle results.
    always_comb begin
        loaded_prev_d = tape_loaded_q;
        motor_d       = motor;
        sup_d         = sup_q;
        if (load_evt || dl_rise) begin
            sup_d = 1'b0;
        end else if (rew_rise && (dl_fall || pend_q)) begin
            sup_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loaded_prev_q <= 1'b0;
            motor_q       <= 1'b0;
            sup_q         <= 1'b0;
        end else begin
            loaded_prev_q <= loaded_prev_d;
            motor_q       <= motor_d;
            sup_q         <= sup_d;
        end
    end

    assign toggle = rew_rise | (load_evt & ~sup_q) | runout;
`else
    assign toggle = rew_rise;
`endif

    always_comb begin
        max_addr_d    = max_addr_q;
        any_wr_d      = any_wr_q;
        pend_d        = pend_q;
        tape_end_d    = tape_end_q;
        tape_loaded_d = tape_loaded_q;
        dl_d          = ioctl_download;
        rew_req_d     = rewind_req;
        cas_en_d      = tape_loaded_q & motor & ~ioctl_download;
        rewind_d      = rewind_q ^ toggle;
        if (finalize) begin
            tape_end_d    = any_wr_q ? max_addr_q + AW'(1) : '0;
            tape_loaded_d = any_wr_q;
            pend_d        = 1'b0;
        end else if (dl_fall) begin
            pend_d = 1'b1;
        end
        if (dl_rise) begin
            max_addr_d    = '0;
            any_wr_d      = 1'b0;
            tape_loaded_d = 1'b0;
            pend_d        = 1'b0;
        end
        if (state_q == WR) begin
            any_wr_d = 1'b1;
            if (buf_addr > max_addr_d) begin
                max_addr_d = buf_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            rd_addr_q     <= '0;
            wait_cnt_q    <= '0;
            cas_data_q    <= '0;
            max_addr_q    <= '0;
            any_wr_q      <= 1'b0;
            pend_q        <= 1'b0;
            tape_end_q    <= '0;
            tape_loaded_q <= 1'b0;
            cas_en_q      <= 1'b0;
            rewind_q      <= 1'b0;
            dl_q          <= 1'b0;
            rew_req_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            wait_cnt_q    <= wait_cnt_d;
            cas_data_q    <= cas_data_d;
            max_addr_q    <= max_addr_d;
            any_wr_q      <= any_wr_d;
            pend_q        <= pend_d;
            tape_end_q    <= tape_end_d;
            tape_loaded_q <= tape_loaded_d;
            cas_en_q      <= cas_en_d;
            rewind_q      <= rewind_d;
            dl_q          <= dl_d;
            rew_req_q     <= rew_req_d;
        end
    end

    assign ioctl_wait  = buf_full;
    assign cas_data    = cas_data_q;
    assign cas_en      = cas_en_q;
    assign cas_rewind  = rewind_q;
    assign tape_end    = tape_end_q;
    assign tape_loaded = tape_loaded_q;

endmodule
